// File: rtl/ascon_round_ctrl_if.sv
// ascon_round_ctrl_if: start/done handshakes and datapath controls of the Ascon round sequencer
interface ascon_round_ctrl_if #(parameter int CNT_W = 16);
   logic             start_valid, start_ready, mode, abort;
   logic             state_en, state_sel, busy, done_valid, done_ready;
   logic [3:0]       rc_idx;
   logic [CNT_W-1:0] perm_cnt;
   modport master (
      output start_valid, mode, abort, done_ready,
      input  start_ready, state_en, state_sel, rc_idx, busy, done_valid, perm_cnt
   );
   modport slave (
      input  start_valid, mode, abort, done_ready,
      output start_ready, state_en, state_sel, rc_idx, busy, done_valid, perm_cnt
   );
endinterface

// File: rtl/ascon_round_ctrl.sv
// ascon_round_ctrl: sequences LOAD and p^a/p^b rounds for the Ascon state register
module ascon_round_ctrl #(
   parameter int ROUNDS_A = 12,
   parameter int ROUNDS_B = 6,
   parameter int CNT_W    = 16
) (
   input logic              clk,
   input logic              rst_n,
   ascon_round_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;
   localparam logic [3:0] RA = 4'(ROUNDS_A);
   localparam logic [3:0] RB = 4'(ROUNDS_B);
   state_t           state, nxt;
   logic [3:0]       nrounds, rnd;
   logic [CNT_W-1:0] cnt;
   logic             accept, handshake;
   assign accept    = state == IDLE && bus.start_valid && !bus.abort;
   assign handshake = state == DONE && bus.done_ready && !bus.abort;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         nrounds <= '0;
         rnd     <= '0;
         cnt     <= '0;
      end else begin
         state <= nxt;
         if (accept) nrounds <= bus.mode ? RB : RA;
         rnd <= (bus.abort || state != ROUND) ? 4'd0 : rnd + 4'd1;
         if (handshake) cnt <= cnt + 1'b1;
      end
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = bus.start_valid ? LOAD : IDLE;
         LOAD:    nxt = ROUND;
         ROUND:   nxt = (rnd == nrounds - 4'd1) ? DONE : ROUND;
         default: nxt = bus.done_ready ? IDLE : DONE;
      endcase
      if (bus.abort) nxt = IDLE;
   end
   // state_en is the only output gated combinationally (by abort); the rest are pure Moore
   assign bus.start_ready = state == IDLE;
   assign bus.state_en    = (state == LOAD || state == ROUND) && !bus.abort;
   assign bus.state_sel   = state == ROUND;
   assign bus.rc_idx      = state == ROUND ? 4'd12 - nrounds + rnd : 4'd0;
   assign bus.busy        = state == LOAD || state == ROUND;
   assign bus.done_valid  = state == DONE;
   assign bus.perm_cnt    = cnt;
endmodule

// File: tb/tb_ascon_round_ctrl.sv
// tb_ascon_round_ctrl: directed checks of the Ascon round sequencer with a 2-bit permutation counter
module tb_ascon_round_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
  ascon_round_ctrl_if #(.CNT_W(2)) bus ();
  ascon_round_ctrl #(.ROUNDS_A(12), .ROUNDS_B(6), .CNT_W(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(input string tag, input logic [1:0] c);
    chk({tag, "_ready"}, bus.start_ready, 1);
    chk({tag, "_en"}, bus.state_en, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_dv"}, bus.done_valid, 0);
    chk({tag, "_cnt"}, bus.perm_cnt, c);
  endtask
  task automatic start(input logic m);
    bus.start_valid = 1'b1;
    bus.mode = m;
    tick();
    bus.start_valid = 1'b0;
    chk("load_en", bus.state_en, 1);
    chk("load_sel", bus.state_sel, 0);
    chk("load_busy", bus.busy, 1);
    chk("load_ready", bus.start_ready, 0);
  endtask
  task automatic rounds(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      tick();
      chk("rnd_en", bus.state_en, 1);
      chk("rnd_sel", bus.state_sel, 1);
      chk("rnd_idx", bus.rc_idx, i);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    bus.start_valid = 1'b0;
    bus.mode = 1'b0;
    bus.abort = 1'b0;
    bus.done_ready = 1'b0;
    tick();
    tick();
    idle_chk("reset", 2'd0);
    chk("reset_idx", bus.rc_idx, 0);
    rst_n = 1'b1;
    tick();
    idle_chk("idle", 2'd0);
    bus.done_ready = 1'b1;
    start(1'b0);
    rounds(0, 11);
    tick();
    chk("p12_dv", bus.done_valid, 1);
    chk("p12_done_en", bus.state_en, 0);
    chk("p12_done_idx", bus.rc_idx, 0);
    tick();
    idle_chk("p12_end", 2'd1);
    bus.done_ready = 1'b0;
    start(1'b1);
    rounds(6, 11);
    for (int c = 8; c <= 12; c++) begin
      tick();
      chk("bp_dv", bus.done_valid, 1);
      chk("bp_en", bus.state_en, 0);
      chk("bp_ready", bus.start_ready, 0);
    end
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    idle_chk("bp_end", 2'd2);
    bus.done_ready = 1'b1;
    bus.start_valid = 1'b1;
    bus.mode = 1'b1;
    tick();
    chk("b2b_load1", bus.state_en, 1);
    rounds(6, 11);
    tick();
    chk("b2b_dv1", bus.done_valid, 1);
    chk("b2b_ready_done", bus.start_ready, 0);
    tick();
    idle_chk("b2b_gap", 2'd3);
    tick();
    bus.start_valid = 1'b0;
    chk("b2b_load2_en", bus.state_en, 1);
    chk("b2b_load2_sel", bus.state_sel, 0);
    rounds(6, 11);
    tick();
    chk("b2b_dv2", bus.done_valid, 1);
    tick();
    idle_chk("wrap", 2'd0);
    start(1'b0);
    rounds(0, 4);
    tick();
    chk("abort_idx", bus.rc_idx, 5);
    bus.abort = 1'b1;
    #1;
    chk("abort_en", bus.state_en, 0);
    tick();
    bus.abort = 1'b0;
    idle_chk("abort_idle", 2'd0);
    start(1'b1);
    rounds(6, 11);
    tick();
    chk("post_abort_dv", bus.done_valid, 1);
    tick();
    idle_chk("post_abort", 2'd1);
    bus.done_ready = 1'b0;
    start(1'b1);
    rounds(6, 11);
    tick();
    chk("ab_done_dv", bus.done_valid, 1);
    bus.abort = 1'b1;
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    idle_chk("ab_done", 2'd1);
    bus.start_valid = 1'b1;
    #1;
    chk("ab_idle_ready", bus.start_ready, 1);
    tick();
    bus.start_valid = 1'b0;
    bus.abort = 1'b0;
    idle_chk("ab_idle", 2'd1);
    start(1'b0);
    rounds(0, 5);
    chk("pre_rst_idx", bus.rc_idx, 5);
    rst_n = 1'b0;
    tick();
    idle_chk("mid_rst", 2'd0);
    chk("mid_rst_idx", bus.rc_idx, 0);
    chk("mid_rst_sel", bus.state_sel, 0);
    rst_n = 1'b1;
    bus.done_ready = 1'b1;
    start(1'b1);
    rounds(6, 11);
    tick();
    tick();
    idle_chk("post_rst", 2'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
